// File: rtl/forwarding_hazard_unit_pkg.sv
// Shared definitions for the EX-stage forwarding / load-use hazard unit.
package forwarding_hazard_unit_pkg;

    localparam int DEF_REG_ADDR_W = 5;
    localparam int DEF_CNT_W      = 16;

    // Operand mux selector encoding; 2'b11 is never produced.
    typedef enum logic [1:0] {
        FWD_REGFILE = 2'b00,
        FWD_WB      = 2'b01,
        FWD_MEM     = 2'b10
    } fwd_sel_e;

endpackage

// File: rtl/forwarding_hazard_unit_if.sv
// ID-side decode fields in, forwarding selectors and pipeline enables out.
interface forwarding_hazard_unit_if #(
    parameter int REG_ADDR_W = 5,
    parameter int CNT_W      = 16
);
    logic                  id_valid;
    logic [REG_ADDR_W-1:0] id_rs;
    logic [REG_ADDR_W-1:0] id_rt;
    logic                  id_uses_rs;
    logic                  id_uses_rt;
    logic [REG_ADDR_W-1:0] id_dst;
    logic                  id_regwrite;
    logic                  id_memread;
    logic                  branch_flush;
    logic                  freeze;

    logic [1:0]            forward_a;
    logic [1:0]            forward_b;
    logic                  pc_write;
    logic                  if_id_write;
    logic                  id_ex_bubble;
    logic [CNT_W-1:0]      stall_count;

    // Pipeline / decode side
    modport master (
        output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dst,
               id_regwrite, id_memread, branch_flush, freeze,
        input  forward_a, forward_b, pc_write, if_id_write, id_ex_bubble, stall_count
    );

    // Hazard unit side
    modport slave (
        input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_dst,
               id_regwrite, id_memread, branch_flush, freeze,
        output forward_a, forward_b, pc_write, if_id_write, id_ex_bubble, stall_count
    );
endinterface

// File: rtl/forwarding_hazard_unit_fwd_select.sv
// One operand's forwarding selector: compares the EX source register against
// the MEM and WB destination tags; the younger (MEM) producer wins.
module fwd_select
    import forwarding_hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W
) (
    input  logic [REG_ADDR_W-1:0] src_i,
    input  logic                  uses_i,
    input  logic                  ex_valid_i,
    input  logic                  mem_valid_i,
    input  logic                  mem_regwrite_i,
    input  logic [REG_ADDR_W-1:0] mem_dst_i,
    input  logic                  wb_valid_i,
    input  logic                  wb_regwrite_i,
    input  logic [REG_ADDR_W-1:0] wb_dst_i,
    output fwd_sel_e              sel_o
);
    logic mem_hit;
    logic wb_hit;

    // $0 is hardwired zero, so it is never a forwarding source.
    assign mem_hit = ex_valid_i & uses_i & mem_valid_i & mem_regwrite_i &
                     (mem_dst_i != '0) & (mem_dst_i == src_i);
    assign wb_hit  = ex_valid_i & uses_i & wb_valid_i & wb_regwrite_i &
                     (wb_dst_i != '0) & (wb_dst_i == src_i);

    // Priority select: MEM result is newer than WB data.
    always_comb begin
        sel_o = FWD_REGFILE;
        if (mem_hit)     sel_o = FWD_MEM;
        else if (wb_hit) sel_o = FWD_WB;
    end
endmodule

// File: rtl/forwarding_hazard_unit.sv
// Forwarding selectors and load-use stall control for a 5-stage MIPS pipe.
// Tracks its own EX/MEM/WB destination tags, so only ID decode fields are needed.
module forwarding_hazard_unit
    import forwarding_hazard_unit_pkg::*;
#(
    parameter int REG_ADDR_W = DEF_REG_ADDR_W,
    parameter int CNT_W      = DEF_CNT_W
) (
    input  logic                    clk,
    input  logic                    reset,
    forwarding_hazard_unit_if.slave bus
);
    typedef struct packed {
        logic                  valid;
        logic [REG_ADDR_W-1:0] dst;
        logic                  regwrite;
        logic                  memread;
    } tag_t;

    typedef struct packed {
        tag_t                  t;
        logic [REG_ADDR_W-1:0] rs;
        logic [REG_ADDR_W-1:0] rt;
        logic                  uses_rs;
        logic                  uses_rt;
    } ex_tag_t;

    ex_tag_t          ex_q,  ex_d;
    tag_t             mem_q, mem_d;
    tag_t             wb_q,  wb_d;
    logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

    fwd_sel_e sel_a, sel_b;
    logic     hz;
    logic     unused_tag_bits;

    // WB memread is carried for completeness but nothing downstream consumes it.
    assign unused_tag_bits = wb_q.memread;

    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_a (
        .src_i(ex_q.rs), .uses_i(ex_q.uses_rs), .ex_valid_i(ex_q.t.valid),
        .mem_valid_i(mem_q.valid), .mem_regwrite_i(mem_q.regwrite), .mem_dst_i(mem_q.dst),
        .wb_valid_i(wb_q.valid), .wb_regwrite_i(wb_q.regwrite), .wb_dst_i(wb_q.dst),
        .sel_o(sel_a)
    );

    fwd_select #(.REG_ADDR_W(REG_ADDR_W)) u_fwd_b (
        .src_i(ex_q.rt), .uses_i(ex_q.uses_rt), .ex_valid_i(ex_q.t.valid),
        .mem_valid_i(mem_q.valid), .mem_regwrite_i(mem_q.regwrite), .mem_dst_i(mem_q.dst),
        .wb_valid_i(wb_q.valid), .wb_regwrite_i(wb_q.regwrite), .wb_dst_i(wb_q.dst),
        .sel_o(sel_b)
    );

    // Load in EX whose result the ID instruction reads; a flushed ID never stalls.
    assign hz = bus.id_valid & ~bus.branch_flush & ex_q.t.valid & ex_q.t.memread &
                (ex_q.t.dst != '0) &
                ((bus.id_uses_rs & (bus.id_rs == ex_q.t.dst)) |
                 (bus.id_uses_rt & (bus.id_rt == ex_q.t.dst)));

    // Output control: reset forces defaults, freeze beats hazard.
    always_comb begin
        bus.forward_a    = sel_a;
        bus.forward_b    = sel_b;
        bus.pc_write     = 1'b1;
        bus.if_id_write  = 1'b1;
        bus.id_ex_bubble = 1'b0;
        if (reset) begin
            bus.forward_a = FWD_REGFILE;
            bus.forward_b = FWD_REGFILE;
        end else if (bus.freeze) begin
            bus.pc_write    = 1'b0;
            bus.if_id_write = 1'b0;
        end else if (hz) begin
            bus.pc_write     = 1'b0;
            bus.if_id_write  = 1'b0;
            bus.id_ex_bubble = 1'b1;
        end
    end

    assign bus.stall_count = stall_cnt_q;

    // Next-state: advance tags unless frozen; a stall/flush/empty ID injects a bubble.
    always_comb begin
        ex_d        = ex_q;
        mem_d       = mem_q;
        wb_d        = wb_q;
        stall_cnt_d = stall_cnt_q;
        if (!bus.freeze) begin
            wb_d  = mem_q;
            mem_d = ex_q.t;
            if (hz || bus.branch_flush || !bus.id_valid) begin
                ex_d = '0;
            end else begin
                ex_d.t.valid    = 1'b1;
                ex_d.t.dst      = bus.id_dst;
                ex_d.t.regwrite = bus.id_regwrite;
                ex_d.t.memread  = bus.id_memread;
                ex_d.rs         = bus.id_rs;
                ex_d.rt         = bus.id_rt;
                ex_d.uses_rs    = bus.id_uses_rs;
                ex_d.uses_rt    = bus.id_uses_rt;
            end
            if (hz && (stall_cnt_q != '1))
                stall_cnt_d = stall_cnt_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Tag and counter registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            ex_q        <= '0;
            mem_q       <= '0;
            wb_q        <= '0;
            stall_cnt_q <= '0;
        end else begin
            ex_q        <= ex_d;
            mem_q       <= mem_d;
            wb_q        <= wb_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end
endmodule

// File: tb/tb_forwarding_hazard_unit.sv
// Scoreboard bench: stimulus pushes expected outputs from an instruction-level
// model of the pipeline; a negedge monitor pops and compares.
module tb_forwarding_hazard_unit;
    import forwarding_hazard_unit_pkg::*;

    localparam int AW = 5;
    localparam int CW = 16;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    forwarding_hazard_unit_if #(.REG_ADDR_W(AW), .CNT_W(CW)) bus ();

    forwarding_hazard_unit #(.REG_ADDR_W(AW), .CNT_W(CW)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );

    typedef struct {
        bit v;
        int rs, rt, dst;
        bit urs, urt, rw, mr;
    } ins_t;

    typedef struct {
        int fa, fb;
        bit pc, ifid, bub;
        int cnt;
    } exp_t;

    exp_t sb[$];
    ins_t pipe[3];      // 0 = EX, 1 = MEM, 2 = WB: instruction occupying each stage
    int   cnt_m;
    int   tests = 0;
    int   fails = 0;
    int   cyc   = 0;
    bit   hold;

    function automatic ins_t mk(bit v, int rs, int rt, bit urs, bit urt, int dst, bit rw, bit mr);
        ins_t i;
        i.v = v; i.rs = rs; i.rt = rt; i.urs = urs; i.urt = urt;
        i.dst = dst; i.rw = rw; i.mr = mr;
        return i;
    endfunction

    function automatic ins_t bubble();
        return mk(0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    // Nearest older instruction that writes the source register supplies it.
    function automatic int fwd_of(int src, bit uses);
        if (!pipe[0].v || !uses) return 0;
        for (int k = 1; k <= 2; k++)
            if (pipe[k].v && pipe[k].rw && pipe[k].dst != 0 && pipe[k].dst == src)
                return (k == 1) ? 2 : 1;
        return 0;
    endfunction

    function automatic bit hazard(ins_t id, bit flush);
        if (!id.v || flush || !pipe[0].v || !pipe[0].mr || pipe[0].dst == 0) return 0;
        return (id.urs && id.rs == pipe[0].dst) || (id.urt && id.rt == pipe[0].dst);
    endfunction

    // One cycle: drive ID, record expectation, advance the model across the edge.
    task automatic step(ins_t id, bit flush, bit frz, bit rst);
        exp_t e;
        bit   hz;
        @(posedge clk);
        #1;
        reset            = rst;
        bus.id_valid     = id.v;
        bus.id_rs        = AW'(id.rs);
        bus.id_rt        = AW'(id.rt);
        bus.id_uses_rs   = id.urs;
        bus.id_uses_rt   = id.urt;
        bus.id_dst       = AW'(id.dst);
        bus.id_regwrite  = id.rw;
        bus.id_memread   = id.mr;
        bus.branch_flush = flush;
        bus.freeze       = frz;
        hz    = hazard(id, flush);
        e.cnt = cnt_m;
        if (rst) begin
            e.fa = 0; e.fb = 0; e.pc = 1; e.ifid = 1; e.bub = 0;
        end else begin
            e.fa = fwd_of(pipe[0].rs, pipe[0].urs);
            e.fb = fwd_of(pipe[0].rt, pipe[0].urt);
            if (frz) begin
                e.pc = 0; e.ifid = 0; e.bub = 0;
            end else begin
                e.pc = !hz; e.ifid = !hz; e.bub = hz;
            end
        end
        sb.push_back(e);
        hold = !rst && (frz || hz);
        if (rst) begin
            for (int k = 0; k < 3; k++) pipe[k] = bubble();
            cnt_m = 0;
        end else if (!frz) begin
            if (hz && cnt_m < (1 << CW) - 1) cnt_m++;
            pipe[2] = pipe[1];
            pipe[1] = pipe[0];
            pipe[0] = (hz || flush || !id.v) ? bubble() : id;
        end
    endtask

    // Issue an instruction, re-presenting it while the pipe holds IF/ID.
    task automatic issue(ins_t id, bit flush);
        step(id, flush, 0, 0);
        for (int n = 0; n < 4 && hold; n++) step(id, flush, 0, 0);
    endtask

    // Monitor: the unit presents a full output set every cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            cyc++;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                tests++;
                if ({bus.forward_a, bus.forward_b, bus.pc_write, bus.if_id_write,
                     bus.id_ex_bubble, bus.stall_count} !==
                    {2'(e.fa), 2'(e.fb), e.pc, e.ifid, e.bub, CW'(e.cnt)}) begin
                    fails++;
                    $display("FAIL outputs cyc=%0d got fa=%0d fb=%0d pc=%0b ifid=%0b bub=%0b cnt=%0d exp fa=%0d fb=%0d pc=%0b ifid=%0b bub=%0b cnt=%0d",
                             cyc, bus.forward_a, bus.forward_b, bus.pc_write, bus.if_id_write,
                             bus.id_ex_bubble, bus.stall_count,
                             e.fa, e.fb, e.pc, e.ifid, e.bub, e.cnt);
                end
            end
        end
    end

    initial begin
        ins_t nop, cur;
        bit   fl, fz, rs;
        nop = mk(1, 0, 0, 0, 0, 0, 0, 0);
        for (int k = 0; k < 3; k++) pipe[k] = bubble();
        cnt_m = 0;
        hold  = 0;
        bus.id_valid = 0; bus.id_rs = '0; bus.id_rt = '0; bus.id_uses_rs = 0;
        bus.id_uses_rt = 0; bus.id_dst = '0; bus.id_regwrite = 0; bus.id_memread = 0;
        bus.branch_flush = 0; bus.freeze = 0;

        // Reset state observed while reset is held
        step(nop, 0, 0, 1);
        // add $3,$1,$2 ; sub $4,$3,$5  -> MEM forward on A
        issue(mk(1, 1, 2, 1, 1, 3, 1, 0), 0);
        issue(mk(1, 3, 5, 1, 1, 4, 1, 0), 0);
        issue(nop, 0); issue(nop, 0); issue(nop, 0);
        // add $3 ; nop ; or $6,$7,$3  -> WB forward on B
        issue(mk(1, 1, 2, 1, 1, 3, 1, 0), 0);
        issue(nop, 0);
        issue(mk(1, 7, 3, 1, 1, 6, 1, 0), 0);
        issue(nop, 0); issue(nop, 0); issue(nop, 0);
        // two nops in between -> regfile
        issue(mk(1, 1, 2, 1, 1, 3, 1, 0), 0);
        issue(nop, 0); issue(nop, 0);
        issue(mk(1, 7, 3, 1, 1, 6, 1, 0), 0);
        issue(nop, 0); issue(nop, 0); issue(nop, 0);
        // lw $2,0($1) ; add $4,$2,$2  -> one stall then WB forward on both
        issue(mk(1, 1, 0, 1, 0, 2, 1, 1), 0);
        issue(mk(1, 2, 2, 1, 1, 4, 1, 0), 0);
        issue(nop, 0); issue(nop, 0); issue(nop, 0);
        // writes to $0 never forward
        issue(mk(1, 1, 1, 1, 1, 0, 1, 0), 0);
        issue(mk(1, 0, 0, 1, 1, 5, 1, 0), 0);
        issue(nop, 0); issue(nop, 0); issue(nop, 0);
        // load-use squashed by branch flush
        issue(mk(1, 1, 0, 1, 0, 2, 1, 1), 0);
        issue(mk(1, 2, 2, 1, 1, 4, 1, 0), 1);
        issue(nop, 0); issue(nop, 0); issue(nop, 0);
        // load-use held by freeze for 3 cycles, then one bubble
        issue(mk(1, 1, 0, 1, 0, 2, 1, 1), 0);
        cur = mk(1, 2, 2, 1, 1, 4, 1, 0);
        step(cur, 0, 1, 0); step(cur, 0, 1, 0); step(cur, 0, 1, 0);
        issue(cur, 0);
        issue(nop, 0); issue(nop, 0); issue(nop, 0);
        // reset asserted mid-stall
        issue(mk(1, 1, 0, 1, 0, 2, 1, 1), 0);
        step(cur, 0, 0, 0);
        step(cur, 0, 0, 1);
        issue(cur, 0);
        issue(nop, 0); issue(nop, 0);

        // Random traffic over a small register range to provoke dependences
        cur = nop;
        for (int i = 0; i < 2000; i++) begin
            if (!hold) begin
                cur.v   = ($urandom_range(0, 99) < 85);
                cur.rs  = $urandom_range(0, 3);
                cur.rt  = $urandom_range(0, 3);
                cur.dst = $urandom_range(0, 3);
                cur.urs = $urandom_range(0, 1);
                cur.urt = $urandom_range(0, 1);
                cur.mr  = ($urandom_range(0, 99) < 35);
                cur.rw  = cur.mr | ($urandom_range(0, 99) < 70);
            end
            fl = ($urandom_range(0, 99) < 8);
            fz = ($urandom_range(0, 99) < 10);
            rs = ($urandom_range(0, 99) < 2);
            step(cur, fl, fz, rs);
        end

        repeat (3) @(negedge clk);
        #1;
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain got %0d pending expectations, exp 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
